// File: rtl/pixel_row_sequencer_pkg.sv
// Shared constants and state encoding for the pixel-row sequencer.
package pixel_row_sequencer_pkg;

    localparam int ROW_COUNT = 28;
    localparam int SEL_BIT   = 5;
    localparam int PASS_BIT  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/pixel_row_sequencer_counter.sv
// Row-select counter: clears to row 0, steps by one on advance, and flags the
// last row so the sequencer can wrap or finish.  It never steps past the last row.
module pixel_row_counter
    import pixel_row_sequencer_pkg::*;
#(
    parameter int ROW_COUNT_P = ROW_COUNT,
    parameter int SEL_BIT_P   = SEL_BIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 advance,
    output logic [SEL_BIT_P-1:0] sel,
    output logic                 tc
);

    assign tc = (sel == SEL_BIT_P'(ROW_COUNT_P - 1));

    // Select register: clear wins over advance; the terminal row is a hard stop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel <= '0;
        end else if (clear) begin
            sel <= '0;
        end else if (advance && !tc) begin
            sel <= sel + SEL_BIT_P'(1);
        end
    end

endmodule

// File: rtl/pixel_row_sequencer.sv
// Pixel-row sequencer: sweeps the row mux select through every row of a locked
// frame once per pass, one row per valid/ready transfer, and pulses Done at the end.
module pixel_row_sequencer
    import pixel_row_sequencer_pkg::*;
#(
    parameter int ROW_COUNT_P = ROW_COUNT,
    parameter int SEL_BIT_P   = SEL_BIT,
    parameter int PASS_BIT_P  = PASS_BIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic [PASS_BIT_P-1:0] NumPasses,
    input  logic                  Abort,
    input  logic                  RowReady,
    output logic [SEL_BIT_P-1:0]  Select,
    output logic                  RowValid,
    output logic                  RowLast,
    output logic [PASS_BIT_P-1:0] PassIdx,
    output logic                  FrameLock,
    output logic                  Busy,
    output logic                  Done
);

    state_t                  state;
    state_t                  state_next;
    logic [PASS_BIT_P-1:0]   pass_idx;
    logic [PASS_BIT_P-1:0]   pass_next;
    logic [PASS_BIT_P-1:0]   last_pass;
    logic [PASS_BIT_P-1:0]   last_next;
    logic                    sel_clear;
    logic                    sel_advance;
    logic                    row_tc;
    logic                    xfer;
    logic                    on_last_pass;

    pixel_row_counter #(
        .ROW_COUNT_P (ROW_COUNT_P),
        .SEL_BIT_P   (SEL_BIT_P)
    ) u_row_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (sel_clear),
        .advance (sel_advance),
        .sel     (Select),
        .tc      (row_tc)
    );

    assign xfer         = (state == ST_SWEEP) && RowReady;
    assign on_last_pass = (pass_idx == last_pass);

    // State, pass index and latched last-pass index.  A reset leaves the
    // latched pass count at one sweep (last index 0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pass_idx  <= '0;
            last_pass <= '0;
        end else begin
            state     <= state_next;
            pass_idx  <= pass_next;
            last_pass <= last_next;
        end
    end

    // Next-state and counter control.  Abort beats both Start and a coincident
    // transfer; a wrap from the last row into the next pass costs no cycle.
    always_comb begin
        state_next  = state;
        pass_next   = pass_idx;
        last_next   = last_pass;
        sel_clear   = 1'b0;
        sel_advance = 1'b0;
        case (state)
            ST_IDLE: begin
                sel_clear = 1'b1;
                pass_next = '0;
                if (Start && !Abort) begin
                    state_next = ST_SWEEP;
                    last_next  = (NumPasses == '0) ? '0 : (NumPasses - PASS_BIT_P'(1));
                end
            end
            ST_SWEEP: begin
                if (Abort) begin
                    state_next = ST_IDLE;
                    sel_clear  = 1'b1;
                    pass_next  = '0;
                end else if (xfer) begin
                    if (row_tc) begin
                        sel_clear = 1'b1;
                        if (on_last_pass) begin
                            state_next = ST_DONE;
                            pass_next  = '0;
                        end else begin
                            pass_next = pass_idx + PASS_BIT_P'(1);
                        end
                    end else begin
                        sel_advance = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                sel_clear  = 1'b1;
                pass_next  = '0;
                state_next = ST_IDLE;
            end
            default: begin
                sel_clear  = 1'b1;
                pass_next  = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    assign PassIdx   = pass_idx;
    assign RowValid  = (state == ST_SWEEP);
    assign Busy      = (state != ST_IDLE);
    assign FrameLock = Busy;
    assign Done      = (state == ST_DONE);
    assign RowLast   = RowValid && row_tc && on_last_pass;

endmodule

// File: tb/tb_pixel_row_sequencer.sv
// Self-checking bench for pixel_row_sequencer: directed jobs plus randomized
// jobs, checked against a transfer-list reference model.
module tb_pixel_row_sequencer;

    localparam int ROWS = 28;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] num_passes;
    logic       abort;
    logic       row_ready;
    logic [4:0] select;
    logic       row_valid;
    logic       row_last;
    logic [3:0] pass_idx;
    logic       frame_lock;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    pixel_row_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .Start     (start),
        .NumPasses (num_passes),
        .Abort     (abort),
        .RowReady  (row_ready),
        .Select    (select),
        .RowValid  (row_valid),
        .RowLast   (row_last),
        .PassIdx   (pass_idx),
        .FrameLock (frame_lock),
        .Busy      (busy),
        .Done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  int'(busy),       0);
        chk({tag, "_lock"},  int'(frame_lock), 0);
        chk({tag, "_valid"}, int'(row_valid),  0);
        chk({tag, "_done"},  int'(done),       0);
        chk({tag, "_last"},  int'(row_last),   0);
        chk({tag, "_sel"},   int'(select),     0);
        chk({tag, "_pass"},  int'(pass_idx),   0);
    endtask

    // One job from Start to Done (or to Abort).  The model is the ordered list of
    // transfers: transfer k carries row k%ROWS of pass k/ROWS, the final one is
    // RowLast, and Done must appear exactly the cycle after it.  Called and
    // returning at a drive point (1 time unit after a rising edge).
    task automatic run_job(input int np, input int ready_pct, input bit noise,
                           input int stall_idx, input int abort_idx,
                           output int done_cyc);
        int  total;
        int  idx;
        int  stalls;
        int  c;
        bit  fin;
        total    = ((np == 0) ? 1 : np) * ROWS;
        idx      = 0;
        stalls   = 0;
        c        = 1;
        fin      = 1'b0;
        done_cyc = -1;
        start      = 1'b1;
        num_passes = 4'(np);
        abort      = 1'b0;
        row_ready  = 1'($urandom_range(1));
        @(negedge clk);
        chk("start_cycle_busy", int'(busy), 0);
        @(posedge clk); #1;
        while (!fin && c <= 3000) begin
            row_ready = ($urandom_range(99) < ready_pct);
            if (idx == stall_idx && stalls < 3) begin
                row_ready = 1'b0;
                stalls++;
            end
            start = noise ? 1'($urandom_range(1)) : 1'b0;
            abort = (idx == abort_idx);
            if (abort) row_ready = 1'b1;
            @(negedge clk);
            if (idx < total) begin
                chk("row_valid", int'(row_valid),  1);
                chk("done_early", int'(done),      0);
                chk("busy",      int'(busy),       1);
                chk("lock",      int'(frame_lock), 1);
                chk("select",    int'(select),     idx % ROWS);
                chk("pass_idx",  int'(pass_idx),   idx / ROWS);
                chk("row_last",  int'(row_last),   int'(idx == total - 1));
                if (row_ready && !abort) idx++;
            end else begin
                chk("done_valid", int'(row_valid), 0);
                chk("done_pulse", int'(done),      1);
                chk("done_busy",  int'(busy),      1);
                chk("xfer_count", idx,             total);
                done_cyc = c;
            end
            @(posedge clk); #1;
            if (abort || done_cyc >= 0) begin
                abort     = 1'b0;
                start     = 1'b0;
                row_ready = 1'b0;
                @(negedge clk);
                chk_idle(done_cyc >= 0 ? "after_done" : "after_abort");
                @(posedge clk); #1;
                fin = 1'b1;
            end
            c++;
        end
        if (!fin) chk("job_timeout", 0, 1);
    endtask

    initial begin
        int dc;
        rst        = 1'b1;
        start      = 1'b0;
        num_passes = 4'd0;
        abort      = 1'b0;
        row_ready  = 1'b0;
        #12;
        chk_idle("reset");
        #11 rst = 1'b0;
        @(posedge clk); #1;

        // Baseline: one pass, always ready.
        run_job(1, 100, 1'b0, -1, -1, dc);
        chk("baseline_done_cycle", dc, 29);

        // Three-cycle stall while row 5 is presented.
        run_job(1, 100, 1'b0, 5, -1, dc);
        chk("stall_done_cycle", dc, 32);

        // Three passes back to back.
        run_job(3, 100, 1'b0, -1, -1, dc);
        chk("three_pass_done_cycle", dc, 85);

        // Zero passes behaves as one.
        run_job(0, 100, 1'b0, -1, -1, dc);
        chk("zero_pass_done_cycle", dc, 29);

        // Abort at row 10 with a coincident ready, then a clean full job.
        run_job(1, 100, 1'b0, -1, 10, dc);
        chk("abort_no_done", dc, -1);
        run_job(1, 100, 1'b0, -1, -1, dc);
        chk("post_abort_done_cycle", dc, 29);

        // Abort in IDLE overrides Start.
        start = 1'b1; abort = 1'b1; num_passes = 4'd1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk_idle("idle_abort");
        @(posedge clk); #1;

        // Start noise during the sweep and the Done cycle, random readiness.
        run_job(2, 70, 1'b1, -1, -1, dc);
        chk("noise_done_seen", int'(dc > 0), 1);

        // Asynchronous reset in the middle of a sweep.
        start = 1'b1; num_passes = 4'd2; row_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_idle("async_reset");
        @(negedge clk); rst = 1'b0;
        row_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk_idle("after_reset");
        @(posedge clk); #1;
        run_job(1, 100, 1'b0, -1, -1, dc);
        chk("post_reset_done_cycle", dc, 29);

        // Randomized jobs.
        for (int j = 0; j < 6; j++) begin
            int np;
            int pct;
            np  = int'($urandom_range(5));
            pct = int'($urandom_range(100, 30));
            run_job(np, pct, 1'($urandom_range(1)), -1,
                    ($urandom_range(3) == 0) ? int'($urandom_range(40)) : -1, dc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
